// File: rtl/ftf_seg_scheduler_if.sv
// Handshake bundle for the segment scheduler: word in, shared-encoder port, code word out.
// slave = scheduler side, master = producer/consumer/encoder side.
`ifndef FBLEN07
`define FBLEN07 7
`endif

interface ftf_seg_scheduler_if #(
    parameter int NSEG  = 4,
    parameter int SEG_W = `FBLEN07
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [NSEG*SEG_W-1:0]   in_data;
    logic [SEG_W-1:0]        enc_datain;
    logic [6:0]              enc_codeout;
    logic                    out_valid;
    logic                    out_ready;
    logic [NSEG*7-1:0]       out_code;
    logic                    busy;
    logic [15:0]             word_cnt;

    modport slave (
        input  in_valid, in_data, enc_codeout, out_ready,
        output in_ready, enc_datain, out_valid, out_code, busy, word_cnt
    );

    modport master (
        output in_valid, in_data, enc_codeout, out_ready,
        input  in_ready, enc_datain, out_valid, out_code, busy, word_cnt
    );
endinterface

// File: rtl/ftf_seg_scheduler.sv
// Time-multiplexes NSEG segments of a word through one shared 7-bit encoder (1-cycle latency).
// Latency accept->out_valid NSEG+2 cycles; holds out_code until out_ready, min period NSEG+3.
`ifndef FBLEN07
`define FBLEN07 7
`endif

module ftf_seg_scheduler #(
    parameter int NSEG  = 4,
    parameter int SEG_W = `FBLEN07
) (
    input  logic                   clock,
    input  logic                   rst_n,
    ftf_seg_scheduler_if.slave     bus
);
    localparam int            CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                       state_q,    state_d;
    logic [CW-1:0]                feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]                cap_cnt_q,  cap_cnt_d;
    logic                         cap_vld_q,  cap_vld_d;
    logic [NSEG-1:0][SEG_W-1:0]   data_q,     data_d;
    logic [NSEG-1:0][6:0]         code_q,     code_d;
    logic [15:0]                  word_cnt_q, word_cnt_d;

    logic accept;
    logic out_hs;

    assign accept = (state_q == IDLE) && bus.in_valid;
    assign out_hs = (state_q == HOLD) && bus.out_ready;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)                     state_d = FEED;
            FEED:    if (feed_cnt_q == LAST)               state_d = DRAIN;
            DRAIN:   if (cap_vld_q && cap_cnt_q == LAST)   state_d = HOLD;
            HOLD:    if (bus.out_ready)                    state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    // Datapath next-state: the capture side replays the feed counter one cycle
    // later, matching the encoder's register stage.
    always_comb begin
        feed_cnt_d = '0;
        if (state_q == FEED && feed_cnt_q != LAST) begin
            feed_cnt_d = feed_cnt_q + CW'(1);
        end

        cap_vld_d = (state_q == FEED);
        cap_cnt_d = (state_q == FEED) ? feed_cnt_q : cap_cnt_q;

        data_d = data_q;
        if (accept) begin
            data_d = bus.in_data;
        end

        code_d = code_q;
        if (cap_vld_q) begin
            code_d[cap_cnt_q] = bus.enc_codeout;
        end

        word_cnt_d = word_cnt_q;
        if (out_hs) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            feed_cnt_q <= '0;
            cap_cnt_q  <= '0;
            cap_vld_q  <= 1'b0;
            data_q     <= '0;
            code_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            cap_vld_q  <= cap_vld_d;
            data_q     <= data_d;
            code_q     <= code_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // The encoder sees zero whenever no segment is being fed.
    assign bus.enc_datain = (state_q == FEED) ? data_q[feed_cnt_q] : '0;
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_code   = code_q;
    assign bus.word_cnt   = word_cnt_q;

    a_feed_range: assert property (@(posedge clock) disable iff (!rst_n) feed_cnt_q <= LAST);
    a_cap_range:  assert property (@(posedge clock) disable iff (!rst_n) cap_cnt_q <= LAST);
    a_excl_hs:    assert property (@(posedge clock) disable iff (!rst_n) !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_ftf_seg_scheduler.sv
// Bench for ftf_seg_scheduler: XOR-55 encoder stub, cycle-level reference model, directed + random stimulus.
module tb_ftf_seg_scheduler;
    localparam int NSEG    = 4;
    localparam int SEG_W   = 7;
    localparam int W       = NSEG * SEG_W;
    localparam int HOLD_AT = NSEG + 2;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    ftf_seg_scheduler_if #(.NSEG(NSEG), .SEG_W(SEG_W)) bus ();

    ftf_seg_scheduler #(.NSEG(NSEG), .SEG_W(SEG_W)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] enc_q = '0;
    always @(posedge clock) enc_q <= bus.enc_datain ^ 7'h55;
    assign bus.enc_codeout = enc_q;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [SEG_W-1:0] seg_of(logic [W-1:0] w, int k);
        return w[k*SEG_W +: SEG_W];
    endfunction

    // Reference model: cycle offset from the accept cycle, the latched word,
    // the codes captured so far and the handshake count.
    int                   m_phase = -1;
    logic [W-1:0]         m_word  = '0;
    logic [NSEG-1:0][6:0] m_code  = '0;
    logic [15:0]          m_cnt   = '0;
    logic                 preload = 1'b0;

    initial begin
        logic [SEG_W-1:0] exp_enc;
        forever begin
            @(negedge clock);
            if (preload) m_cnt = 16'hFFFF;
            if (!rst_n) begin
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_busy",      32'(bus.busy), 0);
                chk("rst_enc",       32'(bus.enc_datain), 0);
                chk("rst_code",      32'(bus.out_code), 0);
                chk("rst_cnt",       32'(bus.word_cnt), 0);
                m_phase = -1;
                m_code  = '0;
                m_cnt   = '0;
            end else begin
                exp_enc = (m_phase >= 1 && m_phase <= NSEG) ? seg_of(m_word, m_phase - 1) : '0;
                chk("in_ready",  32'(bus.in_ready),   32'(m_phase < 0));
                chk("busy",      32'(bus.busy),       32'(m_phase >= 0));
                chk("out_valid", 32'(bus.out_valid),  32'(m_phase >= HOLD_AT));
                chk("enc_datain",32'(bus.enc_datain), 32'(exp_enc));
                chk("out_code",  32'(bus.out_code),   32'(m_code));
                chk("word_cnt",  32'(bus.word_cnt),   32'(m_cnt));
                if (m_phase < 0) begin
                    if (bus.in_valid) begin
                        m_word  = bus.in_data;
                        m_phase = 1;
                    end
                end else if (m_phase >= HOLD_AT) begin
                    if (bus.out_ready) begin
                        m_phase = -1;
                        m_cnt   = m_cnt + 16'd1;
                    end
                end else begin
                    if (m_phase >= 2) m_code[m_phase-2] = seg_of(m_word, m_phase - 2) ^ 7'h55;
                    m_phase++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [6:0]   exp_seg [NSEG];
        logic [W-1:0] exp_code;
        int           last_acc;
        int           n_acc;

        // 28'h1234567 split into 7-bit fields, low field first: 67, 0A, 0D, 09
        exp_seg  = '{7'h67, 7'h0A, 7'h0D, 7'h09};
        exp_code = {7'h5C, 7'h58, 7'h5F, 7'h32};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        repeat (3) step();

        // Accept on the very first edge after reset release
        step();
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(28'h1234567);
        @(negedge clock);
        chk("first_in_ready", 32'(bus.in_ready), 1);
        for (int k = 0; k < NSEG; k++) begin
            step();
            bus.in_valid = 1'b0;
            bus.in_data  = W'($urandom);
            @(negedge clock);
            chk("lit_enc_seg", 32'(bus.enc_datain), 32'(exp_seg[k]));
        end
        step();
        @(negedge clock);
        chk("lit_no_valid_T5", 32'(bus.out_valid), 0);
        step();
        @(negedge clock);
        chk("lit_valid_T6", 32'(bus.out_valid), 1);
        chk("lit_code_T6",  32'(bus.out_code), 32'(exp_code));
        repeat (10) begin
            step();
            @(negedge clock);
            chk("lit_hold_valid", 32'(bus.out_valid), 1);
            chk("lit_hold_code",  32'(bus.out_code), 32'(exp_code));
            chk("lit_hold_rdy",   32'(bus.in_ready), 0);
            chk("lit_hold_cnt",   32'(bus.word_cnt), 0);
        end
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("lit_cnt_after_hs",  32'(bus.word_cnt), 1);
        chk("lit_idle_after_hs", 32'(bus.in_ready), 1);
        chk("lit_code_kept",     32'(bus.out_code), 32'(exp_code));

        // Reset pulse in cycle T+3 discards the partial word
        step();
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (8) begin
            step();
            @(negedge clock);
            chk("abort_no_valid", 32'(bus.out_valid), 0);
            chk("abort_code_zero", 32'(bus.out_code), 0);
        end
        step();
        bus.in_valid  = 1'b1;
        bus.in_data   = W'($urandom);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) step();
        @(negedge clock);
        chk("abort_next_cnt", 32'(bus.word_cnt), 1);

        // Back-to-back streaming: accepts every NSEG+3 cycles
        last_acc = -1;
        n_acc    = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            bus.in_data   = W'($urandom);
            @(negedge clock);
            if (bus.in_ready) begin
                if (last_acc >= 0) chk("stream_spacing", 32'(i - last_acc), 7);
                last_acc = i;
                n_acc++;
            end
        end
        chk("stream_accepts", 32'(n_acc), 9);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.in_data   = W'($urandom);
            rst_n         = ($urandom_range(0, 199) != 0);
        end
        step();
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (12) step();

        // Counter wrap from 0xFFFF
        step();
        force dut.word_cnt_q = 16'hFFFF;
        preload = 1'b1;
        @(negedge clock);
        chk("wrap_preload", 32'(bus.word_cnt), 32'h0000FFFF);
        step();
        release dut.word_cnt_q;
        preload      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom);
        step();
        bus.in_valid = 1'b0;
        repeat (8) step();
        @(negedge clock);
        chk("wrap_to_zero", 32'(bus.word_cnt), 0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
